// File: rtl/sdrc_wb_traffic_gen.sv
// Wishbone burst traffic generator for the SDRAM controller slave port.
// Issues incrementing bursts with a seed+k data pattern and checks read data against the same pattern.
module sdrc_wb_traffic_gen #(
  parameter int AW     = 32,
  parameter int DW     = 32,
  parameter int LW     = 4,
  parameter int TO_CYC = 1024,
  parameter int ECW    = 16
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LW-1:0]   cmd_len,
  input  logic [DW-1:0]   cmd_seed,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic            wb_ack_i,
  input  logic [DW-1:0]   wb_dat_i,
  output logic            busy,
  output logic            done,
  output logic            timeout,
  output logic [ECW-1:0]  err_cnt,
  output logic [AW-1:0]   err_addr
);

  localparam int BPB = DW / 8;
  localparam int WDW = $clog2(TO_CYC + 1);
  localparam logic [2:0] CTI_CLS = 3'b000;
  localparam logic [2:0] CTI_INC = 3'b010;
  localparam logic [2:0] CTI_EOB = 3'b111;

  typedef enum logic [1:0] {IDLE, BURST, FIN} state_t;

  typedef struct packed {
    logic          we;
    logic [LW-1:0] len;
    logic [DW-1:0] seed;
  } cmd_t;

  state_t         state_q, state_d;
  cmd_t           cmd_q, cmd_d;
  logic [LW-1:0]  k_q, k_d, len1;
  logic [WDW-1:0] wd_q, wd_d;

  logic            rdy_d, cyc_d, stb_d, we_d, done_d, to_d;
  logic [AW-1:0]   addr_d, ea_d;
  logic [DW-1:0]   dat_d;
  logic [2:0]      cti_d;
  logic [ECW-1:0]  ec_d;

  logic accept, ack_ok, last, to_hit;

  assign accept   = (state_q == IDLE) && cmd_ready && cmd_valid;
  assign ack_ok   = wb_stb_o && wb_ack_i;
  assign last     = (k_q == cmd_q.len - LW'(1));
  assign to_hit   = wb_stb_o && !wb_ack_i && (wd_q == WDW'(TO_CYC - 1));
  assign wb_sel_o = '1;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state_q <= IDLE;
    else          state_q <= state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = BURST;
      BURST:   if ((ack_ok && last) || to_hit) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    rdy_d  = cmd_ready;
    cyc_d  = wb_cyc_o;
    stb_d  = wb_stb_o;
    we_d   = wb_we_o;
    addr_d = wb_addr_o;
    dat_d  = wb_dat_o;
    cti_d  = wb_cti_o;
    done_d = 1'b0;
    to_d   = timeout;
    ec_d   = err_cnt;
    ea_d   = err_addr;
    cmd_d  = cmd_q;
    k_d    = k_q;
    wd_d   = wd_q;
    len1   = (cmd_len == '0) ? LW'(1) : cmd_len;
    case (state_q)
      IDLE: begin
        rdy_d = 1'b1;
        if (accept) begin
          cmd_d  = '{we: cmd_we, len: len1, seed: cmd_seed};
          k_d    = '0;
          wd_d   = '0;
          to_d   = 1'b0;
          rdy_d  = 1'b0;
          cyc_d  = 1'b1;
          stb_d  = 1'b1;
          we_d   = cmd_we;
          addr_d = cmd_addr;
          dat_d  = cmd_seed;
          cti_d  = (len1 == LW'(1)) ? CTI_CLS : CTI_INC;
        end
      end
      BURST: begin
        if (ack_ok) begin
          wd_d = '0;
          if (!cmd_q.we && (wb_dat_i != cmd_q.seed + DW'(k_q))) begin
            if (err_cnt != '1) ec_d = err_cnt + ECW'(1);
            ea_d = wb_addr_o;
          end
          if (last) begin
            cyc_d  = 1'b0;
            stb_d  = 1'b0;
            we_d   = 1'b0;
            cti_d  = CTI_CLS;
            done_d = 1'b1;
          end else begin
            k_d    = k_q + LW'(1);
            addr_d = wb_addr_o + AW'(BPB);
            dat_d  = wb_dat_o + DW'(1);
            cti_d  = (k_q + LW'(2) == cmd_q.len) ? CTI_EOB : CTI_INC;
          end
        end else if (to_hit) begin
          // Watchdog abort: late acks are ignored because stb is already low.
          cyc_d  = 1'b0;
          stb_d  = 1'b0;
          we_d   = 1'b0;
          cti_d  = CTI_CLS;
          to_d   = 1'b1;
          done_d = 1'b1;
        end else if (wb_stb_o) begin
          wd_d = wd_q + WDW'(1);
        end
      end
      FIN:     rdy_d = 1'b1;
      default: rdy_d = 1'b0;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      cmd_ready <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_cti_o  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      err_cnt   <= '0;
      err_addr  <= '0;
      cmd_q     <= '0;
      k_q       <= '0;
      wd_q      <= '0;
    end else begin
      cmd_ready <= rdy_d;
      wb_cyc_o  <= cyc_d;
      wb_stb_o  <= stb_d;
      wb_we_o   <= we_d;
      wb_addr_o <= addr_d;
      wb_dat_o  <= dat_d;
      wb_cti_o  <= cti_d;
      busy      <= (state_d != IDLE);
      done      <= done_d;
      timeout   <= to_d;
      err_cnt   <= ec_d;
      err_addr  <= ea_d;
      cmd_q     <= cmd_d;
      k_q       <= k_d;
      wd_q      <= wd_d;
    end

endmodule

// File: tb/tb_sdrc_wb_traffic_gen.sv
// Scoreboard bench for sdrc_wb_traffic_gen: a behavioural Wishbone slave with memory,
// expected beats and burst results queued at issue time and checked by a monitor.
module tb_sdrc_wb_traffic_gen;
  localparam int AW = 32, DW = 32, LW = 4, ECW = 16, TO = 16;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  logic            cmd_valid = 1'b0, cmd_ready, cmd_we = 1'b0;
  logic [AW-1:0]   cmd_addr = '0;
  logic [LW-1:0]   cmd_len = '0;
  logic [DW-1:0]   cmd_seed = '0;
  logic            wb_cyc_o, wb_stb_o, wb_we_o, ack = 1'b0;
  logic [AW-1:0]   wb_addr_o, err_addr;
  logic [DW-1:0]   wb_dat_o, dat_i = '0;
  logic [DW/8-1:0] wb_sel_o;
  logic [2:0]      wb_cti_o;
  logic            busy, done, timeout;
  logic [ECW-1:0]  err_cnt;

  sdrc_wb_traffic_gen #(.AW(AW), .DW(DW), .LW(LW), .TO_CYC(TO), .ECW(ECW)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_we(cmd_we), .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_seed(cmd_seed),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_addr_o(wb_addr_o),
    .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_cti_o(wb_cti_o), .wb_ack_i(ack),
    .wb_dat_i(dat_i), .busy(busy), .done(done), .timeout(timeout),
    .err_cnt(err_cnt), .err_addr(err_addr));

  typedef struct {logic we; logic [31:0] addr; logic [31:0] dat; logic [2:0] cti;} beat_t;
  typedef struct {logic to; logic [15:0] ec; logic [31:0] ea; int cyc;} burst_t;

  beat_t  bq[$];
  burst_t rq[$];
  int n_chk = 0, n_fail = 0;

  int          waits = 0, bad_beat = -1;
  bit          noack = 1'b0;
  logic [31:0] bad_val = '0;
  logic [31:0] mem [logic [31:0]];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic flag(input string nm);
    n_chk++;
    n_fail++;
    $display("FAIL %s (t=%0t)", nm, $time);
  endtask

  // Slave: decides ack shortly after each rising edge so it is stable by the next one.
  initial begin
    int wc, bt;
    wc = 0; bt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (wb_cyc_o && wb_stb_o && !noack) begin
        if (wc == waits) begin
          ack = 1'b1;
          wc = 0;
          if (wb_we_o) mem[wb_addr_o] = wb_dat_o;
          else dat_i = (bt == bad_beat) ? bad_val :
                       (mem.exists(wb_addr_o) ? mem[wb_addr_o] : 32'h0);
          bt++;
        end else begin
          ack = 1'b0;
          wc++;
        end
      end else begin
        ack = 1'b0;
        wc = 0;
        if (!wb_cyc_o) bt = 0;
      end
    end
  end

  // Monitor: checks each acked beat, hold-through-wait, and each done pulse.
  initial begin
    int cyc_cnt;
    bit pw;
    logic [31:0] pa, pd;
    beat_t b;
    burst_t r;
    cyc_cnt = 0; pw = 1'b0; pa = '0; pd = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cyc_cnt = 0;
        pw = 1'b0;
      end else begin
        if (pw && wb_stb_o) begin
          chk("hold_addr", wb_addr_o, pa);
          chk("hold_dat", wb_dat_o, pd);
        end
        if (wb_cyc_o) cyc_cnt++;
        if (wb_cyc_o && wb_stb_o && ack) begin
          if (bq.size() == 0) flag("unexpected_beat");
          else begin
            b = bq.pop_front();
            chk("beat_addr", wb_addr_o, b.addr);
            chk("beat_dat", wb_dat_o, b.dat);
            chk("beat_cti", wb_cti_o, b.cti);
            chk("beat_we", wb_we_o, b.we);
          end
        end
        pw = wb_cyc_o && wb_stb_o && !ack;
        pa = wb_addr_o;
        pd = wb_dat_o;
        if (done) begin
          if (rq.size() == 0) flag("unexpected_done");
          else begin
            r = rq.pop_front();
            chk("done_timeout", timeout, r.to);
            chk("done_err_cnt", err_cnt, r.ec);
            chk("done_err_addr", err_addr, r.ea);
            chk("cyc_cycles", cyc_cnt, r.cyc);
            chk("beats_left", bq.size(), 0);
          end
          cyc_cnt = 0;
        end
      end
    end
  end

  task automatic expect_done(input logic to, input logic [15:0] ec, input logic [31:0] ea, input int cyc);
    burst_t r;
    r.to = to; r.ec = ec; r.ea = ea; r.cyc = cyc;
    rq.push_back(r);
  endtask

  task automatic send(input logic we, input logic [31:0] addr, input logic [3:0] len,
                      input logic [31:0] seed, input bit exp_beats);
    int n, t;
    beat_t b;
    n = (len == 0) ? 1 : int'(len);
    t = 0;
    @(negedge clk);
    while (!cmd_ready && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) flag("cmd_ready_bound");
    if (exp_beats)
      for (int k = 0; k < n; k++) begin
        b.we = we;
        b.addr = addr + 32'(k) * 32'd4;
        b.dat = seed + 32'(k);
        b.cti = (n == 1) ? 3'b000 : (k == n - 1) ? 3'b111 : 3'b010;
        bq.push_back(b);
      end
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_seed = seed;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    chk("ready_after_accept", cmd_ready, 1'b0);
    chk("busy_after_accept", busy, 1'b1);
  endtask

  task automatic wait_done();
    int t;
    t = 0;
    while ((rq.size() != 0 || busy) && t < 300) begin @(negedge clk); t++; end
    if (t >= 300) flag("done_bound");
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_cyc", wb_cyc_o, 1'b0);
    chk("rst_stb", wb_stb_o, 1'b0);
    chk("rst_we", wb_we_o, 1'b0);
    chk("rst_addr", wb_addr_o, 32'h0);
    chk("rst_dat", wb_dat_o, 32'h0);
    chk("rst_cti", wb_cti_o, 3'b000);
    chk("rst_sel", wb_sel_o, 4'hF);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_timeout", timeout, 1'b0);
    chk("rst_err_cnt", err_cnt, 16'h0);
    chk("rst_err_addr", err_addr, 32'h0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("ready_after_rst", cmd_ready, 1'b1);

    // Write burst, back-to-back acks
    expect_done(1'b0, 16'd0, 32'h0, 4);
    send(1'b1, 32'h100, 4'd4, 32'hA0, 1'b1);
    wait_done();

    // Read back, clean
    expect_done(1'b0, 16'd0, 32'h0, 4);
    send(1'b0, 32'h100, 4'd4, 32'hA0, 1'b1);
    wait_done();

    // Read back with beat 1 corrupted to 0xA2
    bad_beat = 1; bad_val = 32'hA2;
    expect_done(1'b0, 16'd1, 32'h104, 4);
    send(1'b0, 32'h100, 4'd4, 32'hA0, 1'b1);
    wait_done();
    bad_beat = -1;

    // len=0 acts as a single beat
    expect_done(1'b0, 16'd1, 32'h104, 1);
    send(1'b1, 32'h20, 4'd0, 32'h55, 1'b1);
    wait_done();

    // Three wait states per beat
    waits = 3;
    expect_done(1'b0, 16'd1, 32'h104, 8);
    send(1'b1, 32'h40, 4'd2, 32'h10, 1'b1);
    wait_done();
    waits = 0;

    // Watchdog abort
    noack = 1'b1;
    expect_done(1'b1, 16'd1, 32'h104, 16);
    send(1'b1, 32'h80, 4'd3, 32'h0, 1'b0);
    wait_done();
    chk("timeout_sticky", timeout, 1'b1);
    noack = 1'b0;

    // Next command clears timeout
    expect_done(1'b0, 16'd1, 32'h104, 1);
    send(1'b1, 32'h200, 4'd1, 32'h77, 1'b1);
    chk("timeout_cleared", timeout, 1'b0);
    wait_done();

    // Reset during beat 2 of an 8-beat burst
    send(1'b1, 32'h300, 4'd8, 32'h0, 1'b1);
    @(posedge clk);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("rst_mid_cyc", wb_cyc_o, 1'b0);
    chk("rst_mid_stb", wb_stb_o, 1'b0);
    chk("rst_mid_ready", cmd_ready, 1'b0);
    bq.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("post_rst_ready", cmd_ready, 1'b1);
    chk("post_rst_err_cnt", err_cnt, 16'h0);
    chk("post_rst_timeout", timeout, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    repeat (10) @(negedge clk);
    chk("no_pending_done", rq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit (t=%0t)", $time);
    $fatal(1);
  end
endmodule

// File: doc/sdrc_wb_traffic_gen.md
Name: sdrc_wb_traffic_gen

Overview:
- Synthesizable Wishbone master that sits directly upstream of the SDRAM controller's Wishbone slave port and drives its wb_* inputs.
- Accepts burst commands (address, length, direction, seed) and issues incrementing Wishbone bursts. Write data comes from a deterministic pattern.
- Read data is checked against the same pattern, giving self-checking traffic for controller regressions at all three SDRAM widths.

Parameters:
- AW, 32, Wishbone byte-address width
- DW, 32, Wishbone data width (8/16/32)
- LW, 4, burst-length field width; max burst 2**LW-1 beats
- TO_CYC, 1024, cycles without ack before a burst is aborted
- ECW, 16, error-counter width

Ports:
- wb_clk_i  in  1  system clock; all logic on rising edge
- wb_rst_i  in  1  asynchronous reset, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when valid&ready
- cmd_we  in  1  1=write burst, 0=read-and-check burst
- cmd_addr  in  AW  start byte address
- cmd_len  in  LW  beats; 0 treated as 1
- cmd_seed  in  DW  pattern seed
- wb_cyc_o  out  1  bus cycle
- wb_stb_o  out  1  strobe
- wb_we_o  out  1  write enable
- wb_addr_o  out  AW  beat byte address
- wb_dat_o  out  DW  write data
- wb_sel_o  out  DW/8  byte selects, all ones
- wb_cti_o  out  3  cycle type
- wb_ack_i  in  1  slave acknowledge
- wb_dat_i  in  DW  read data
- busy  out  1  FSM not IDLE
- done  out  1  one-cycle pulse at burst end
- timeout  out  1  sticky; set on abort, cleared on next accepted command
- err_cnt  out  ECW  saturating count of read mismatches
- err_addr  out  AW  address of most recent mismatch

Behaviour:
- Reset values: cmd_ready=0 while reset is asserted and 1 after release. All wb_* outputs 0, except wb_sel_o, which is all ones. busy=0, done=0, timeout=0, err_cnt=0, err_addr=0.
- FSM states are IDLE, BURST and FIN. All outputs are registered.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch we, addr, len (0 becomes 1) and seed. Clear beat counter k, watchdog and timeout. Go to BURST.
  - wb_cyc_o and wb_stb_o rise in the cycle after acceptance.
- BURST:
  - cyc=stb=1, wb_we_o=latched we, wb_addr_o=addr+k*(DW/8) (mod 2**AW), wb_dat_o=seed+k (mod 2**DW).
  - wb_cti_o: 3'b000 if len==1; otherwise 3'b010 for beats 0..len-2 and 3'b111 for the last beat.
  - On each wb_ack_i the current beat completes. Address, data and cti for beat k+1 are presented in the following cycle. Back-to-back acks complete one beat per cycle.
  - Read beat: if wb_dat_i != seed+k, increment err_cnt (saturating at all ones) and set err_addr to the beat address, both on the ack edge.
  - When the last beat is acked, cyc, stb, we and cti drop to 0 in the next cycle, and the FSM goes to FIN.
  - Watchdog counts cycles with stb=1 and no ack, and resets on each ack. When it reaches TO_CYC: drop cyc/stb, set timeout=1, go to FIN. Acks arriving after the abort are ignored.
- FIN: done=1 for exactly one cycle, cmd_ready=0, then return to IDLE.
- cmd_ready is 0 from the acceptance edge through FIN. Commands presented in that window are not accepted.
- wb_ack_i while stb=0 is ignored.
- wb_rst_i asserted mid-burst: cyc/stb clear asynchronously and immediately, and all state returns to reset values. No done pulse is generated.
- Width rules: address increments by DW/8 bytes and wraps modulo 2**AW. Data pattern wraps modulo 2**DW.

Test Plan:
- Write, DW=32, addr=0x100, len=4, seed=0xA0, slave acks every cycle. Required:
  - wb_addr_o = 0x100/104/108/10C and wb_dat_o = A0/A1/A2/A3.
  - cti = 010,010,010,111.
  - cyc high for 4 cycles, done pulse in the following cycle.
- Read back the same burst through the controller with the SDRAM model → err_cnt=0 and done=1. Repeat with the slave returning 0xA2 on beat 1 → err_cnt=1, err_addr=0x104.
- len=0, write, addr=0x20 → exactly one beat, cti=000, address 0x20.
- Slave inserts 3 wait cycles per beat, len=2 → stb stays high with address/data stable through the waits. Two beats, total cyc duration 8 cycles.
- TO_CYC=16, slave never acks → cyc drops after 16 cycles, timeout=1, done pulses once. The next accepted command clears timeout.
- Assert wb_rst_i during beat 2 of a len=8 burst → cyc/stb low before the next clock edge, and no done pulse. After release, cmd_ready=1 and err_cnt=0.
